// File: rtl/onehot_scan_encoder_if.sv
// Request-vector in / index-beat out bundle for onehot_scan_encoder.
// slave = the encoder, master = the producer/consumer side driving it.
interface onehot_scan_encoder_if #(
  parameter int WIDTH = 8
) ();
  localparam int IDXW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_code;
  logic             out_first;
  logic             out_last;
  logic             zero_drop;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_first, out_last, zero_drop
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_first, out_last, zero_drop
  );
endinterface

// File: rtl/onehot_scan_encoder.sv
// Handshaked scan encoder: takes a WIDTH-bit request vector and emits the
// index of every set bit, one per output beat, lowest-first or highest-first.
// All-zero vectors are swallowed and flagged with a one-cycle zero_drop pulse.
module onehot_scan_encoder #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_scan_encoder_if.slave  bus
);
  localparam int IDXW = $clog2(WIDTH);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  logic             zdrop_q, zdrop_d;

  logic [IDXW-1:0]  code_c;
  logic             last_c;
  logic             in_scan;

  // Priority pick over the remaining bits. Only indices < WIDTH are visited,
  // so a code >= WIDTH cannot be produced for non-power-of-2 widths.
  if (LSB_FIRST) begin : g_lsb
    // Walk downward so the lowest set bit wins the last assignment.
    always_comb begin
      code_c = '0;
      for (int i = WIDTH - 1; i >= 0; i--)
        if (rem_q[i]) code_c = IDXW'(i);
    end
  end else begin : g_msb
    // Walk upward so the highest set bit wins the last assignment.
    always_comb begin
      code_c = '0;
      for (int i = 0; i < WIDTH; i++)
        if (rem_q[i]) code_c = IDXW'(i);
    end
  end

  // Exactly one bit left means the current beat closes the vector.
  always_comb begin
    last_c = (rem_q != '0) && ((rem_q & (rem_q - WIDTH'(1))) == '0);
  end

  assign in_scan       = (state_q == SCAN);
  assign bus.in_ready  = ~in_scan;
  assign bus.out_valid = in_scan;
  assign bus.out_code  = code_c;
  assign bus.out_first = in_scan & first_q;
  assign bus.out_last  = in_scan & last_c;
  assign bus.zero_drop = zdrop_q;

  // Next-state: accept in IDLE, retire one bit per accepted beat in SCAN.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    first_d = first_q;
    zdrop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_data != '0) begin
            rem_d   = bus.in_data;
            first_d = 1'b1;
            state_d = SCAN;
          end else begin
            zdrop_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.out_ready) begin
          rem_d   = rem_q & ~(WIDTH'(1) << code_c);
          first_d = 1'b0;
          if (last_c) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any partially scanned vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      first_q <= 1'b0;
      zdrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      zdrop_q <= zdrop_d;
    end
  end
endmodule

// File: doc/onehot_scan_encoder.md
# onehot_scan_encoder

Parametrised, handshaked successor to the team's combinational 8-to-3 one-hot encoder. Accepts a WIDTH-bit request vector and emits the binary index of every set bit, one index per output handshake, in a configurable priority order. A pure one-hot input degenerates to a single-beat encode. Multi-hot and all-zero vectors, which the combinational encoder mapped to x, have defined behaviour. Sits between request-vector producers (interrupt/flag registers) and index-consuming logic such as decoders and mux selects.

## Interface
- WIDTH, 8, request vector width; legal range ≥ 2.
- LSB_FIRST, 1, 1 = lowest set index emitted first; 0 = highest first.
- IDXW, $clog2(WIDTH), derived localparam, not overridable; width of out_code.

- clk  input  1  rising-edge clock; the block's single clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a vector.
- in_data  input  WIDTH  request vector.
- out_valid  output  1  out_code valid.
- out_ready  input  1  consumer accepts the current beat.
- out_code  output  IDXW  binary index of the current set bit.
- out_first  output  1  current beat is the first beat of its vector.
- out_last  output  1  current beat is the last beat of its vector.
- zero_drop  output  1  one-cycle pulse: an all-zero vector was accepted and discarded.

## Operation
- Internal state: state (IDLE/SCAN), rem (WIDTH-bit remaining vector), first_r.
- IDLE: in_ready=1, out_valid=0.
  - in_valid=1 and in_data≠0: rem←in_data, first_r←1, go to SCAN.
  - in_valid=1 and in_data=0: stay in IDLE; zero_drop=1 on the next cycle only.
- SCAN: in_ready=0, out_valid=1.
  - out_code = index of the lowest set bit of rem (LSB_FIRST=1) or the highest (LSB_FIRST=0); combinational from rem.
  - out_first = first_r.
  - out_last = 1 when rem has exactly one bit set.
  - On out_valid & out_ready: clear bit out_code in rem and set first_r←0. If out_last=1, go to IDLE.
  - out_ready=0: rem, out_code, out_first and out_last hold stable.
- One-hot input gives exactly one beat with out_first=out_last=1 and out_code equal to the bit position, matching the legacy 8x3 mapping.
- Bits at positions ≥ WIDTH do not exist. out_code values ≥ WIDTH never occur, including for non-power-of-2 WIDTH.
- Reset, at any time including mid-SCAN: state=IDLE, rem=0, first_r=0, zero_drop=0. Any remaining bits are discarded and no further beats are emitted for that vector.
- Output values during and after reset: in_ready=1, out_valid=0, out_code=0, out_first=0, out_last=0, zero_drop=0.

## Timing
- in_ready and out_valid decode directly from state. There is no combinational path from in_valid or out_ready to in_ready or out_valid.
- Vector accepted at edge t: first beat is presented in cycle t+1.
- With out_ready held high, a vector of k set bits produces beats in cycles t+1..t+k. in_ready=1 again in cycle t+k+1, so the next vector can be accepted at the edge ending t+k+1. Minimum period is k+1 cycles per vector.
- A zero vector accepted at edge t: zero_drop=1 in cycle t+1; in_ready stays 1 throughout, so back-to-back acceptance is allowed.
- A single vector never has out_first and out_last asserted on different beats out of order. When k=1, both are asserted on the same beat.
- in_data is sampled only on an in_valid & in_ready edge. Changes to in_data during SCAN have no effect.

## Test plan
- WIDTH=8, LSB_FIRST=1, in_data=8'b1000_0001, out_ready=1 → beat code 0 (first=1,last=0), then code 7 (first=0,last=1); in_ready returns 1 three cycles after acceptance.
- WIDTH=8, in_data=8'b0010_0000 → single beat code 5, first=last=1; all eight one-hot vectors give codes 0..7.
- in_data=8'h00 → zero_drop pulses for exactly one cycle, out_valid stays 0, in_ready stays 1; next vector 8'h02 is accepted the following cycle → code 1.
- LSB_FIRST=0, in_data=8'hFF, out_ready=1 → codes 7,6,…,0, last=1 only on code 0; next accept occurs 9 cycles after the first.
- in_data=8'b0101_0100, out_ready low for 3 cycles after the first beat → out_code=2 with first=1 held stable for all 3 cycles; then codes 2,4,6 in order.
- Assert rst_n=0 mid-SCAN of 8'hF0 after 2 beats → outputs take reset values immediately (asynchronously); after release, no residual beats and in_ready=1.
- WIDTH=5 (IDXW=3), in_data=5'b10010 → codes 1 then 4; no code ≥5 is ever emitted.
